// File: rtl/hqm_aw_rf_pg_seq_pkg.sv
// Shared types and constants for the RF power-gate sequencer.
package hqm_aw_rf_pg_seq_pkg;

  localparam int unsigned ISOL_DLY_DEF    = 4;
  localparam int unsigned RST_CYC_DEF     = 8;
  localparam int unsigned TIMEOUT_CYC_DEF = 256;

  // Encoding order is the sequence order; the FSM advances by +1 with wrap.
  typedef enum logic [2:0] {
    PG_OFF      = 3'd0,
    PG_PU_WAKE  = 3'd1,
    PG_PU_RST   = 3'd2,
    PG_PU_ISOL  = 3'd3,
    PG_ON       = 3'd4,
    PG_PD_DRAIN = 3'd5,
    PG_PD_ISOL  = 3'd6,
    PG_PD_SLEEP = 3'd7
  } pg_state_t;

  typedef struct packed {
    logic isol;
    logic pwr_enable_b;
    logic ip_reset_b;
    logic mem_rdy;
    logic pwr_ack;
  } pg_outs_t;

  // Counter width wide enough for the largest delay, plus one bit.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

  // Interface output values held while in a given state.
  function automatic pg_outs_t state_outs(input pg_state_t s);
    pg_outs_t o;
    case (s)
      PG_OFF:      o = '{isol: 1'b1, pwr_enable_b: 1'b1, ip_reset_b: 1'b0, mem_rdy: 1'b0, pwr_ack: 1'b0};
      PG_PU_WAKE:  o = '{isol: 1'b1, pwr_enable_b: 1'b0, ip_reset_b: 1'b0, mem_rdy: 1'b0, pwr_ack: 1'b0};
      PG_PU_RST:   o = '{isol: 1'b1, pwr_enable_b: 1'b0, ip_reset_b: 1'b0, mem_rdy: 1'b0, pwr_ack: 1'b0};
      PG_PU_ISOL:  o = '{isol: 1'b1, pwr_enable_b: 1'b0, ip_reset_b: 1'b1, mem_rdy: 1'b0, pwr_ack: 1'b0};
      PG_ON:       o = '{isol: 1'b0, pwr_enable_b: 1'b0, ip_reset_b: 1'b1, mem_rdy: 1'b1, pwr_ack: 1'b1};
      PG_PD_DRAIN: o = '{isol: 1'b0, pwr_enable_b: 1'b0, ip_reset_b: 1'b1, mem_rdy: 1'b0, pwr_ack: 1'b1};
      PG_PD_ISOL:  o = '{isol: 1'b1, pwr_enable_b: 1'b0, ip_reset_b: 1'b1, mem_rdy: 1'b0, pwr_ack: 1'b1};
      PG_PD_SLEEP: o = '{isol: 1'b1, pwr_enable_b: 1'b1, ip_reset_b: 1'b0, mem_rdy: 1'b0, pwr_ack: 1'b1};
      default:     o = '{isol: 1'b1, pwr_enable_b: 1'b1, ip_reset_b: 1'b0, mem_rdy: 1'b0, pwr_ack: 1'b0};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/hqm_aw_rf_pg_seq_cnt.sv
// Loadable saturating down-counter shared by all sequencer delays.
// zero_c flags the cycle on which the count reaches (or sits at) zero, so a
// load of N gives exactly N cycles before the owning state advances.
module hqm_aw_rf_pg_seq_cnt #(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         zero_c
);

  // Load has priority; otherwise decrement and hold at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (value != '0) begin
      value <= value - W'(1);
    end
  end

  // Final count cycle: the decrement on this edge lands on zero.
  assign zero_c = (value <= W'(1));

endmodule

// File: rtl/hqm_aw_rf_pg_seq.sv
// Power-gate sequencer driving the PWR interface of a chain of RF wrappers.
module hqm_aw_rf_pg_seq
  import hqm_aw_rf_pg_seq_pkg::*;
#(
  parameter int unsigned ISOL_DLY    = ISOL_DLY_DEF,
  parameter int unsigned RST_CYC     = RST_CYC_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwr_req,
  output logic       pwr_ack,
  input  logic       mem_idle,
  output logic       mem_rdy,
  output logic       pgcb_isol_en,
  output logic       pwr_enable_b,
  input  logic       pwr_enable_b_ret,
  output logic       ip_reset_b,
  output logic       err_timeout,
  output logic [2:0] state_dbg
);

  localparam int unsigned CNT_W = cnt_width(ISOL_DLY, RST_CYC, TIMEOUT_CYC);

  pg_state_t        state;
  pg_outs_t         outs;
  logic             err;
  logic             adv_c;
  logic             cnt_load_c;
  logic [CNT_W-1:0] cnt_load_val_c;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_zero_c;
  pg_state_t        nxt_c;

  hqm_aw_rf_pg_seq_cnt #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load_c),
    .load_val (cnt_load_val_c),
    .value    (cnt_value),
    .zero_c   (cnt_zero_c)
  );

  // Advance condition per state and the delay to load when leaving it.
  always_comb begin
    adv_c          = 1'b0;
    cnt_load_c     = 1'b0;
    cnt_load_val_c = '0;
    case (state)
      PG_OFF: begin
        adv_c          = pwr_req;
        cnt_load_c     = pwr_req;
        cnt_load_val_c = CNT_W'(TIMEOUT_CYC);
      end
      PG_PU_WAKE: begin
        adv_c          = ~pwr_enable_b_ret;
        cnt_load_c     = ~pwr_enable_b_ret;
        cnt_load_val_c = CNT_W'(RST_CYC);
      end
      PG_PU_RST: begin
        adv_c          = cnt_zero_c;
        cnt_load_c     = cnt_zero_c;
        cnt_load_val_c = CNT_W'(ISOL_DLY);
      end
      PG_PU_ISOL:  adv_c = cnt_zero_c;
      PG_ON:       adv_c = ~pwr_req;
      PG_PD_DRAIN: begin
        adv_c          = mem_idle;
        cnt_load_c     = mem_idle;
        cnt_load_val_c = CNT_W'(ISOL_DLY);
      end
      PG_PD_ISOL: begin
        adv_c          = cnt_zero_c;
        cnt_load_c     = cnt_zero_c;
        cnt_load_val_c = CNT_W'(TIMEOUT_CYC);
      end
      PG_PD_SLEEP: adv_c = pwr_enable_b_ret;
      default:     adv_c = 1'b0;
    endcase
    nxt_c = pg_state_t'(3'(state) + 3'd1);
  end

  // Sequencer state, registered interface outputs and sticky timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PG_OFF;
      outs  <= state_outs(PG_OFF);
      err   <= 1'b0;
    end else begin
      if (adv_c) begin
        state <= nxt_c;
        outs  <= state_outs(nxt_c);
      end
      // Chain silent when the wait budget runs out; keep waiting regardless.
      if (cnt_zero_c &&
          (((state == PG_PU_WAKE) && pwr_enable_b_ret) ||
           ((state == PG_PD_SLEEP) && !pwr_enable_b_ret))) begin
        err <= 1'b1;
      end
    end
  end

  assign pgcb_isol_en = outs.isol;
  assign pwr_enable_b = outs.pwr_enable_b;
  assign ip_reset_b   = outs.ip_reset_b;
  assign mem_rdy      = outs.mem_rdy;
  assign pwr_ack      = outs.pwr_ack;
  assign err_timeout  = err;
  assign state_dbg    = 3'(state);

endmodule

// File: tb/tb_hqm_aw_rf_pg_seq.sv
// Self-checking bench for hqm_aw_rf_pg_seq with a delay-line chain model.
module tb_hqm_aw_rf_pg_seq;

  localparam int ISOL = 4;
  localparam int RSTC = 8;
  localparam int TMO  = 256;

  logic       clk = 1'b0;
  logic       rst;
  logic       pwr_req;
  logic       pwr_ack;
  logic       mem_idle;
  logic       mem_rdy;
  logic       pgcb_isol_en;
  logic       pwr_enable_b;
  logic       pwr_enable_b_ret;
  logic       ip_reset_b;
  logic       err_timeout;
  logic [2:0] state_dbg;

  logic [7:0] chain_q = 8'hff;
  int         dly     = 0;
  logic       stuck   = 1'b0;
  int         tests   = 0;
  int         fails   = 0;

  hqm_aw_rf_pg_seq dut (
    .clk              (clk),
    .rst              (rst),
    .pwr_req          (pwr_req),
    .pwr_ack          (pwr_ack),
    .mem_idle         (mem_idle),
    .mem_rdy          (mem_rdy),
    .pgcb_isol_en     (pgcb_isol_en),
    .pwr_enable_b     (pwr_enable_b),
    .pwr_enable_b_ret (pwr_enable_b_ret),
    .ip_reset_b       (ip_reset_b),
    .err_timeout      (err_timeout),
    .state_dbg        (state_dbg)
  );

  always #5 clk = ~clk;

  // Chain of RF wrappers modelled as a dly-cycle delay line.
  always @(posedge clk) chain_q <= {chain_q[6:0], pwr_enable_b};
  assign pwr_enable_b_ret = stuck ? 1'b1 :
                            (dly == 0) ? pwr_enable_b : chain_q[3'(dly - 1)];

  initial begin
    #400000;
    $display("FAIL global_timeout observed=hang required=finish");
    $fatal(1, "timeout");
  end

  function automatic logic [4:0] obs();
    return {pgcb_isol_en, pwr_enable_b, ip_reset_b, mem_rdy, pwr_ack};
  endfunction

  // Expected {isol,pen_b,rst_b,rdy,ack} t edges after pwr_req is first sampled high.
  function automatic logic [4:0] exp_pu(input int t, input int d);
    if (t < 1)               return 5'b11000;
    if (t < 2 + d)           return 5'b10000;
    if (t < 2 + d + RSTC)    return 5'b10000;
    if (t < 2 + d + RSTC + ISOL) return 5'b10100;
    return 5'b00111;
  endfunction

  // Expected tuple t edges after pwr_req is first sampled low in ON.
  function automatic logic [4:0] exp_pd(input int t, input int w, input int d);
    if (t < 1)                    return 5'b00111;
    if (t < 2 + w)                return 5'b00101;
    if (t < 2 + w + ISOL)         return 5'b10101;
    if (t < 3 + w + ISOL + d)     return 5'b11001;
    return 5'b11000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    chk("rdy_safe", 32'(mem_rdy && (pgcb_isol_en || !ip_reset_b)), 32'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk(tag, 32'({obs(), err_timeout, state_dbg}), 32'({5'b11000, 1'b0, 3'd0}));
  endtask

  // Power up with chain delay d; optionally drop pwr_req after two cycles.
  task automatic power_up(input int d, input bit pulse);
    dly = d;
    pwr_req = 1'b1;
    for (int t = 1; t <= 2 + d + RSTC + ISOL; t++) begin
      step();
      if (pulse && t == 2) pwr_req = 1'b0;
      chk($sformatf("pu_d%0d_t%0d", d, t), 32'(obs()), 32'(exp_pu(t, d)));
    end
    chk("pu_on_state", 32'(state_dbg), 32'd4);
  endtask

  // Power down with chain delay d and mem_idle held low for w cycles of drain.
  task automatic power_down(input int d, input int w);
    dly = d;
    pwr_req = 1'b0;
    mem_idle = 1'($urandom);
    for (int t = 1; t <= 4 + w + ISOL + d; t++) begin
      step();
      if (t == 1) mem_idle = 1'b0;
      if (t == 1 + w) mem_idle = 1'b1;
      chk($sformatf("pd_d%0d_w%0d_t%0d", d, w, t), 32'(obs()), 32'(exp_pd(t, w, d)));
    end
    chk("pd_off_state", 32'(state_dbg), 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int n;
    rst = 1'b1;
    pwr_req = 1'b0;
    mem_idle = 1'b1;
    idle(3);
    chk_reset("reset_vals");
    rst = 1'b0;
    idle(8);

    // Directed: chain delay 3, then long drain.
    power_up(3, 1'b0);
    idle(3);
    power_down(3, 10);
    idle(8);

    // Zero-length chain.
    power_up(0, 1'b0);
    power_down(0, 0);
    idle(8);

    // Short request pulse: reach ON, then come straight back down.
    power_up(2, 1'b1);
    power_down(2, 0);
    idle(8);

    // Randomized sequences.
    for (int k = 0; k < 12; k++) begin
      int d, w;
      d = int'($urandom_range(0, 7));
      w = int'($urandom_range(0, 6));
      power_up(d, 1'b0);
      idle(int'($urandom_range(0, 4)));
      power_down(d, w);
      idle(8 + int'($urandom_range(0, 3)));
    end

    // Reset while in PU_RST.
    dly = 3;
    pwr_req = 1'b1;
    idle(7);
    chk("in_pu_rst", 32'(state_dbg), 32'd2);
    rst = 1'b1;
    step();
    chk_reset("reset_in_pu_rst");
    rst = 1'b0;
    pwr_req = 1'b0;
    idle(10);

    // Chain never responds: timeout flags but FSM keeps waiting.
    stuck = 1'b1;
    dly = 0;
    pwr_req = 1'b1;
    for (int t = 1; t <= TMO + 1; t++) begin
      step();
      if (t == TMO) chk("tmo_not_yet", 32'(err_timeout), 32'd0);
    end
    chk("tmo_set", 32'(err_timeout), 32'd1);
    chk("tmo_state", 32'(state_dbg), 32'd1);
    idle(3);
    chk("tmo_still_wake", 32'(state_dbg), 32'd1);
    chk("tmo_ack_low", 32'(pwr_ack), 32'd0);
    stuck = 1'b0;
    n = 0;
    while (pwr_ack !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("tmo_release_latency", 32'(n), 32'(1 + RSTC + ISOL));
    chk("tmo_sticky", 32'(err_timeout), 32'd1);

    // Reset while in PD_SLEEP clears the sticky error.
    dly = 5;
    pwr_req = 1'b0;
    mem_idle = 1'b1;
    n = 0;
    while (state_dbg !== 3'd7 && n < 20) begin
      step();
      n++;
    end
    chk("reach_pd_sleep", 32'(state_dbg), 32'd7);
    step();
    rst = 1'b1;
    step();
    chk_reset("reset_in_pd_sleep");
    rst = 1'b0;
    idle(4);
    chk_reset("off_after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
